// File: rtl/maverickOne_pkg.sv
// Shared core definitions: register-file size, lock counter width and the
// decoded instruction record passed between launcher, lock tracker and execute.
package maverickOne_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_IDX_W  = $clog2(NUM_REGS);
  localparam int LOCK_CNT_W = 2;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [31:0]          imm;
  } decoded_instr_t;

endpackage

// File: rtl/reg_lock_tracker_if.sv
// Bus bundle for reg_lock_tracker: launcher-side input handshake, execute-side
// output handshake, writeback strobe, flush, and the lock/error outputs.
// slave = the tracker, master = whoever drives it.
interface reg_lock_tracker_if #(
  parameter int NUM_REGS = maverickOne_pkg::NUM_REGS
);
  import maverickOne_pkg::*;

  logic                        clear_i;
  decoded_instr_t              instr_in_i;
  logic                        instr_in_valid_i;
  logic                        instr_in_ready_o;
  decoded_instr_t              instr_out_o;
  logic                        instr_out_valid_o;
  logic                        instr_out_ready_i;
  logic                        wb_valid_i;
  logic [$clog2(NUM_REGS)-1:0] wb_rd_i;
  logic [NUM_REGS-1:0]         locks_o;
  logic                        err_o;

  modport slave (
    input  clear_i, instr_in_i, instr_in_valid_i, instr_out_ready_i,
           wb_valid_i, wb_rd_i,
    output instr_in_ready_o, instr_out_o, instr_out_valid_o, locks_o, err_o
  );

  modport master (
    output clear_i, instr_in_i, instr_in_valid_i, instr_out_ready_i,
           wb_valid_i, wb_rd_i,
    input  instr_in_ready_o, instr_out_o, instr_out_valid_o, locks_o, err_o
  );

endinterface

// File: rtl/reg_lock_tracker_counter.sv
// lock_counter: outstanding-write counter for one architectural register.
// Saturates instead of wrapping; a decrement at zero leaves the count alone and
// raises uflow_o for that cycle. A simultaneous inc/dec nets to no change.
// Optional macro REG_LOCK_TRACKER_WB_BYPASS_EN: drain_o flags a writeback that
// retires the last outstanding write, so the lock can drop in that same cycle.
module lock_counter
  import maverickOne_pkg::*;
#(
  parameter int CNT_W = LOCK_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic sat_o,
  output logic nz_o,
  output logic drain_o,
  output logic uflow_o
);

  logic [CNT_W-1:0] cnt;

  assign sat_o   = &cnt;
  assign nz_o    = |cnt;
  assign uflow_o = dec_i & ~inc_i & ~nz_o;

`ifdef REG_LOCK_TRACKER_WB_BYPASS_EN
  assign drain_o = dec_i & ~inc_i & (cnt == CNT_W'(1));
`else
  assign drain_o = 1'b0;
`endif

  // Count up on dispatch, down on writeback, clamped at both ends
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (inc_i & ~dec_i & ~sat_o) begin
      cnt <= cnt + 1'b1;
    end else if (dec_i & ~inc_i & nz_o) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_lock_tracker.sv
// reg_lock_tracker: one-entry buffer between instr_launcher and execute that
// counts outstanding writes per register and publishes the lock vector.
// Optional macro REG_LOCK_TRACKER_WB_BYPASS_EN (in lock_counter): a register
// unlocks in the cycle its final writeback arrives instead of one cycle later.
module reg_lock_tracker
  import maverickOne_pkg::*;
#(
  parameter int NUM_REGS = maverickOne_pkg::NUM_REGS,
  parameter int CNT_W    = LOCK_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  reg_lock_tracker_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REGS);

  decoded_instr_t      buf_p0;
  logic                vld_p0;
  logic [IDX_W-1:0]    rd_p0;
  logic [NUM_REGS-1:0] sat;
  logic [NUM_REGS-1:1] nz;
  logic [NUM_REGS-1:1] drain;
  logic [NUM_REGS-1:1] inc;
  logic [NUM_REGS-1:1] dec;
  logic [NUM_REGS-1:1] uflow;
  logic [NUM_REGS-1:1] pend;
  logic                out_valid;
  logic                dispatch;
  logic                in_ready;
  logic                err_q;

  assign rd_p0 = buf_p0.rd;

  // x0 is never counted, so it can never hold an instruction back
  assign sat[0] = 1'b0;

  // A buffered instruction is held while its rd counter is full or a flush is in progress
  assign out_valid = vld_p0 & ~sat[rd_p0] & ~bus.clear_i;
  assign dispatch  = out_valid & bus.instr_out_ready_i;
  assign in_ready  = ~bus.clear_i & (~vld_p0 | dispatch);

  assign bus.instr_out_o       = buf_p0;
  assign bus.instr_out_valid_o = out_valid;
  assign bus.instr_in_ready_o  = in_ready;
  assign bus.err_o             = err_q;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    assign inc[r]  = dispatch & (rd_p0 == IDX_W'(r));
    assign dec[r]  = bus.wb_valid_i & (bus.wb_rd_i == IDX_W'(r));
    assign pend[r] = vld_p0 & (rd_p0 == IDX_W'(r));

    lock_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (inc[r]),
      .dec_i   (dec[r]),
      .sat_o   (sat[r]),
      .nz_o    (nz[r]),
      .drain_o (drain[r]),
      .uflow_o (uflow[r])
    );
  end

  // The buffered, not-yet-dispatched write also locks its rd; bit 0 is tied low
  assign bus.locks_o = {(nz & ~drain) | pend, 1'b0};

  // stage p0: buffer occupancy, flushed by clear_i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0 <= 1'b0;
    end else if (bus.clear_i) begin
      vld_p0 <= 1'b0;
    end else if (in_ready) begin
      vld_p0 <= bus.instr_in_valid_i;
    end
  end

  // stage p0: instruction payload, loaded on every accepted handshake
  always_ff @(posedge clk_i) begin
    if (in_ready & bus.instr_in_valid_i) begin
      buf_p0 <= bus.instr_in_i;
    end
  end

  // Sticky writeback-underflow flag; survives clear_i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (|uflow) begin
      err_q <= 1'b1;
    end
  end

endmodule
